// File: rtl/sdma_req_ctrl_pkg.sv
// Shared constants and types for the SDMA request sequencer: register map,
// bit positions and the request FSM state encoding.
package sdma_req_ctrl_pkg;

  localparam int unsigned RegCtrl   = 0;
  localparam int unsigned RegThresh = 1;
  localparam int unsigned RegCount  = 2;
  localparam int unsigned RegStatus = 3;

  localparam int unsigned CtrlEnBit     = 0;
  localparam int unsigned CtrlDoneIeBit = 1;
  localparam int unsigned CtrlDmaIeBit  = 2;

  localparam int unsigned StDoneBit = 0;
  localparam int unsigned StDmaBit  = 1;
  localparam int unsigned StBusyBit = 2;
  localparam int unsigned StCompLsb = 16;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StXfer,
    StGap
  } state_e;

  // Expand Wishbone byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/sdma_req_regs.sv
// Wishbone register file for the SDMA request sequencer: CTRL/THRESH/COUNT
// storage, W1C status bits, registered ACK/read data and interrupt levels.
module sdma_req_regs
  import sdma_req_ctrl_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 7,
  parameter int unsigned LVL_WIDTH = 9,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDRWIDTH-1:0] wb_adr_i,
  input  logic                 wb_cyc_i,
  input  logic [3:0]           wb_byte_stb_i,
  input  logic                 wb_we_i,
  input  logic                 wb_stb_i,
  input  logic [31:0]          wb_wr_dat_i,
  output logic [31:0]          wb_rd_dat_o,
  output logic                 wb_ack_o,
  input  logic                 busy_i,
  input  logic [CNT_WIDTH-1:0] completed_i,
  input  logic                 hw_done_set_i,
  input  logic                 hw_dma_set_i,
  input  logic                 hw_en_clr_i,
  output logic                 en_o,
  output logic [LVL_WIDTH-1:0] thresh_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 count_wr_o,
  output logic                 done_intr_o,
  output logic                 dma_intr_o
);

  logic [2:0]           ctrl_q, ctrl_d;
  logic [LVL_WIDTH-1:0] thresh_q, thresh_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 done_st_q, done_st_d;
  logic                 dma_st_q, dma_st_d;
  logic                 ack_q, ack_d;
  logic [31:0]          rd_dat_q, rd_dat_d;
  logic                 done_intr_q, done_intr_d;
  logic                 dma_intr_q, dma_intr_d;

  logic        access, wr;
  logic [31:0] mask, wdat_m, rd_mux;
  logic        w1c_done, w1c_dma, count_wr;

  always_comb begin
    access   = wb_cyc_i & wb_stb_i & ~ack_q;
    wr       = access & wb_we_i;
    mask     = be_mask(wb_byte_stb_i);
    wdat_m   = wb_wr_dat_i & mask;
    ctrl_d   = ctrl_q;
    thresh_d = thresh_q;
    count_d  = count_q;
    count_wr = 1'b0;
    w1c_done = 1'b0;
    w1c_dma  = 1'b0;

    if (wr) begin
      case (wb_adr_i)
        ADDRWIDTH'(RegCtrl):   ctrl_d   = (ctrl_q & ~mask[2:0]) | wdat_m[2:0];
        ADDRWIDTH'(RegThresh): thresh_d = (thresh_q & ~mask[LVL_WIDTH-1:0]) |
                                          wdat_m[LVL_WIDTH-1:0];
        ADDRWIDTH'(RegCount): begin
          count_d  = (count_q & ~mask[CNT_WIDTH-1:0]) | wdat_m[CNT_WIDTH-1:0];
          count_wr = 1'b1;
        end
        ADDRWIDTH'(RegStatus): begin
          w1c_done = wdat_m[StDoneBit];
          w1c_dma  = wdat_m[StDmaBit];
        end
        default: ;
      endcase
    end

    // Hardware events take priority over simultaneous CPU writes.
    if (hw_en_clr_i) ctrl_d[CtrlEnBit] = 1'b0;
    done_st_d = (done_st_q & ~w1c_done) | hw_done_set_i;
    dma_st_d  = (dma_st_q & ~w1c_dma) | hw_dma_set_i;

    // Interrupts track the next-state values so they move with the status bits.
    done_intr_d = done_st_d & ctrl_d[CtrlDoneIeBit];
    dma_intr_d  = dma_st_d & ctrl_d[CtrlDmaIeBit];

    rd_mux = '0;
    case (wb_adr_i)
      ADDRWIDTH'(RegCtrl):   rd_mux[2:0] = ctrl_q;
      ADDRWIDTH'(RegThresh): rd_mux[LVL_WIDTH-1:0] = thresh_q;
      ADDRWIDTH'(RegCount):  rd_mux[CNT_WIDTH-1:0] = count_q;
      ADDRWIDTH'(RegStatus): begin
        rd_mux[StDoneBit]        = done_st_q;
        rd_mux[StDmaBit]         = dma_st_q;
        rd_mux[StBusyBit]        = busy_i;
        rd_mux[StCompLsb +: 16]  = 16'(completed_i);
      end
      default: ;
    endcase

    ack_d    = access;
    rd_dat_d = access ? rd_mux : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q      <= '0;
      thresh_q    <= '0;
      count_q     <= '0;
      done_st_q   <= 1'b0;
      dma_st_q    <= 1'b0;
      ack_q       <= 1'b0;
      rd_dat_q    <= '0;
      done_intr_q <= 1'b0;
      dma_intr_q  <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      thresh_q    <= thresh_d;
      count_q     <= count_d;
      done_st_q   <= done_st_d;
      dma_st_q    <= dma_st_d;
      ack_q       <= ack_d;
      rd_dat_q    <= rd_dat_d;
      done_intr_q <= done_intr_d;
      dma_intr_q  <= dma_intr_d;
    end
  end

  logic unused_wdat;
  assign unused_wdat = ^{wdat_m, mask};

  assign wb_rd_dat_o = rd_dat_q;
  assign wb_ack_o    = ack_q;
  assign en_o        = ctrl_q[CtrlEnBit];
  assign thresh_o    = thresh_q;
  assign count_o     = count_q;
  assign count_wr_o  = count_wr;
  assign done_intr_o = done_intr_q;
  assign dma_intr_o  = dma_intr_q;

endmodule

// File: rtl/sdma_req_ctrl.sv
// SDMA request sequencer: raises burst requests when the FIFO level reaches
// the programmed threshold, tracks Active/Done and counts completed bursts.
module sdma_req_ctrl
  import sdma_req_ctrl_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 7,
  parameter int unsigned LVL_WIDTH = 9,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_CYC_i,
  input  logic [3:0]           WBs_BYTE_STB_i,
  input  logic                 WBs_WE_i,
  input  logic                 WBs_STB_i,
  input  logic [31:0]          WBs_WR_DAT_i,
  output logic [31:0]          WBs_RD_DAT_o,
  output logic                 WBs_ACK_o,
  input  logic [LVL_WIDTH-1:0] fifo_level_i,
  output logic                 SDMA_Req_o,
  output logic                 SDMA_Sreq_o,
  input  logic                 SDMA_Active_i,
  input  logic                 SDMA_Done_i,
  output logic                 fDone_Intr_o,
  output logic                 f_DMA_Intr_o
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] completed_q, completed_d, completed_inc;
  logic                 req_q, req_d;
  logic                 burst_done, done_hit, busy;
  logic                 en, count_wr;
  logic [LVL_WIDTH-1:0] thresh;
  logic [CNT_WIDTH-1:0] count;

  sdma_req_regs #(
    .ADDRWIDTH(ADDRWIDTH),
    .LVL_WIDTH(LVL_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_regs (
    .clk_i        (WB_CLK),
    .rst_i        (WB_RST),
    .wb_adr_i     (WBs_ADR_i),
    .wb_cyc_i     (WBs_CYC_i),
    .wb_byte_stb_i(WBs_BYTE_STB_i),
    .wb_we_i      (WBs_WE_i),
    .wb_stb_i     (WBs_STB_i),
    .wb_wr_dat_i  (WBs_WR_DAT_i),
    .wb_rd_dat_o  (WBs_RD_DAT_o),
    .wb_ack_o     (WBs_ACK_o),
    .busy_i       (busy),
    .completed_i  (completed_q),
    .hw_done_set_i(done_hit),
    .hw_dma_set_i (burst_done),
    .hw_en_clr_i  (done_hit),
    .en_o         (en),
    .thresh_o     (thresh),
    .count_o      (count),
    .count_wr_o   (count_wr),
    .done_intr_o  (fDone_Intr_o),
    .dma_intr_o   (f_DMA_Intr_o)
  );

  always_comb begin
    state_d    = state_q;
    burst_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (en && (thresh != '0) && (fifo_level_i >= thresh)) state_d = StReq;
      end
      StReq: begin
        // A Done that beats Active still counts as a finished burst.
        if (SDMA_Done_i) begin
          burst_done = 1'b1;
          state_d    = StGap;
        end else if (SDMA_Active_i) begin
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (SDMA_Done_i) begin
          burst_done = 1'b1;
          state_d    = StGap;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    completed_inc = completed_q + CNT_WIDTH'(1);
    done_hit      = burst_done && (count != '0) && (completed_inc == count);

    completed_d = completed_q;
    if (count_wr) begin
      completed_d = '0;
    end else if (burst_done) begin
      completed_d = completed_inc;
    end

    req_d = (state_d == StReq);
    busy  = (state_q != StIdle);
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      state_q     <= StIdle;
      completed_q <= '0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      completed_q <= completed_d;
      req_q       <= req_d;
    end
  end

  assign SDMA_Req_o  = req_q;
  assign SDMA_Sreq_o = 1'b0;

endmodule

// File: tb/tb_sdma_req_ctrl.sv
// Self-checking bench for sdma_req_ctrl: register reads are scored against a
// queue of expected values pushed before each access.
module tb_sdma_req_ctrl;
  localparam int unsigned AW = 7;
  localparam int unsigned LW = 9;
  localparam int unsigned CW = 16;

  logic          WB_CLK = 1'b0;
  logic          WB_RST = 1'b1;
  logic [AW-1:0] WBs_ADR_i = '0;
  logic          WBs_CYC_i = 1'b0;
  logic [3:0]    WBs_BYTE_STB_i = '0;
  logic          WBs_WE_i = 1'b0;
  logic          WBs_STB_i = 1'b0;
  logic [31:0]   WBs_WR_DAT_i = '0;
  logic [31:0]   WBs_RD_DAT_o;
  logic          WBs_ACK_o;
  logic [LW-1:0] fifo_level_i = '0;
  logic          SDMA_Req_o;
  logic          SDMA_Sreq_o;
  logic          SDMA_Active_i = 1'b0;
  logic          SDMA_Done_i = 1'b0;
  logic          fDone_Intr_o;
  logic          f_DMA_Intr_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  sdma_req_ctrl #(
    .ADDRWIDTH(AW),
    .LVL_WIDTH(LW),
    .CNT_WIDTH(CW)
  ) dut (
    .WB_CLK        (WB_CLK),
    .WB_RST        (WB_RST),
    .WBs_ADR_i     (WBs_ADR_i),
    .WBs_CYC_i     (WBs_CYC_i),
    .WBs_BYTE_STB_i(WBs_BYTE_STB_i),
    .WBs_WE_i      (WBs_WE_i),
    .WBs_STB_i     (WBs_STB_i),
    .WBs_WR_DAT_i  (WBs_WR_DAT_i),
    .WBs_RD_DAT_o  (WBs_RD_DAT_o),
    .WBs_ACK_o     (WBs_ACK_o),
    .fifo_level_i  (fifo_level_i),
    .SDMA_Req_o    (SDMA_Req_o),
    .SDMA_Sreq_o   (SDMA_Sreq_o),
    .SDMA_Active_i (SDMA_Active_i),
    .SDMA_Done_i   (SDMA_Done_i),
    .fDone_Intr_o  (fDone_Intr_o),
    .f_DMA_Intr_o  (f_DMA_Intr_o)
  );

  always #5 WB_CLK = ~WB_CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wb_xfer(input int adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] be, output logic [31:0] rd);
    int n;
    @(negedge WB_CLK);
    WBs_ADR_i      = AW'(adr);
    WBs_WE_i       = we;
    WBs_WR_DAT_i   = dat;
    WBs_BYTE_STB_i = be;
    WBs_CYC_i      = 1'b1;
    WBs_STB_i      = 1'b1;
    n = 0;
    do begin
      @(negedge WB_CLK);
      n++;
    end while (WBs_ACK_o !== 1'b1 && n < 8);
    rd = WBs_RD_DAT_o;
    n_tests++;
    if (WBs_ACK_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_ack adr=%0d: ack=%b required 1", adr, WBs_ACK_o);
    end
    WBs_CYC_i = 1'b0;
    WBs_STB_i = 1'b0;
    WBs_WE_i  = 1'b0;
  endtask

  task automatic wb_write(input int adr, input logic [31:0] dat, input logic [3:0] be);
    logic [31:0] unused_rd;
    wb_xfer(adr, 1'b1, dat, be, unused_rd);
  endtask

  task automatic wb_read(input int adr, output logic [31:0] rd);
    wb_xfer(adr, 1'b0, '0, 4'hF, rd);
  endtask

  task automatic wait_req(output bit found);
    for (int n = 0; n < 30 && SDMA_Req_o !== 1'b1; n++) @(negedge WB_CLK);
    found = (SDMA_Req_o === 1'b1);
  endtask

  // Answers a pending request with one Active cycle then one Done cycle.
  task automatic serve_burst(output int wait_cyc, output bit ok);
    wait_cyc = 0;
    while (SDMA_Req_o !== 1'b1 && wait_cyc < 30) begin
      @(negedge WB_CLK);
      wait_cyc++;
    end
    ok = (SDMA_Req_o === 1'b1);
    SDMA_Active_i = 1'b1;
    @(negedge WB_CLK);
    SDMA_Active_i = 1'b0;
    SDMA_Done_i   = 1'b1;
    @(negedge WB_CLK);
    SDMA_Done_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d, e;
    bit seen;
    WB_RST = 1'b1;
    repeat (3) @(negedge WB_CLK);
    WB_RST = 1'b0;
    n_tests++;
    if ({SDMA_Req_o, SDMA_Sreq_o, fDone_Intr_o, f_DMA_Intr_o, WBs_ACK_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 00000",
               {SDMA_Req_o, SDMA_Sreq_o, fDone_Intr_o, f_DMA_Intr_o, WBs_ACK_o});
    end
    for (int a = 0; a < 4; a++) exp_q.push_back(32'h0);
    for (int a = 0; a < 4; a++) begin
      wb_read(a, d);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h required %h", a, d, e);
      end
    end
    // THRESH=0 must never trigger, even with EN set and a full FIFO.
    fifo_level_i = '1;
    wb_write(0, 32'h1, 4'hF);
    seen = 1'b0;
    repeat (8) begin
      @(negedge WB_CLK);
      seen |= SDMA_Req_o;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL thresh_zero_no_req: req seen=%b required 0", seen);
    end
    wb_write(0, 32'h0, 4'hF);
    fifo_level_i = '0;
  endtask

  task automatic test_burst;
    logic [31:0] d, e;
    fifo_level_i = 7;
    wb_write(1, 32'd8, 4'hF);
    wb_write(2, 32'd0, 4'hF);
    wb_write(0, 32'h5, 4'hF);
    repeat (3) @(negedge WB_CLK);
    n_tests++;
    if (SDMA_Req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL req_below_thresh: got %b required 0", SDMA_Req_o);
    end
    fifo_level_i = 8;
    @(negedge WB_CLK);
    n_tests++;
    if (SDMA_Req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL req_latency: got %b required 1", SDMA_Req_o);
    end
    SDMA_Active_i = 1'b1;
    @(negedge WB_CLK);
    SDMA_Active_i = 1'b0;
    n_tests++;
    if (SDMA_Req_o !== 1'b0 || f_DMA_Intr_o !== 1'b0) begin
      n_fail++;
      $display("FAIL req_drop: req=%b intr=%b required 0 0", SDMA_Req_o, f_DMA_Intr_o);
    end
    SDMA_Done_i  = 1'b1;
    fifo_level_i = 0;
    @(negedge WB_CLK);
    SDMA_Done_i = 1'b0;
    n_tests++;
    if (f_DMA_Intr_o !== 1'b1) begin
      n_fail++;
      $display("FAIL dma_intr_rise: got %b required 1", f_DMA_Intr_o);
    end
    exp_q.push_back(32'h0001_0002);
    wb_read(3, d);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL status_after_burst: got %h required %h", d, e);
    end
  endtask

  task automatic test_count;
    logic [31:0] d, e;
    int w;
    bit ok, seen;
    wb_write(3, 32'h3, 4'hF);
    wb_write(2, 32'd3, 4'hF);
    fifo_level_i = 16;
    wb_write(0, 32'h7, 4'hF);
    for (int i = 0; i < 3; i++) begin
      serve_burst(w, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL count_burst%0d: req not seen, required 1", i);
      end
      if (i > 0) begin
        n_tests++;
        if (w != 2) begin
          n_fail++;
          $display("FAIL retrigger_gap%0d: waited %0d cycles required 2", i, w);
        end
      end
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge WB_CLK);
      seen |= SDMA_Req_o;
    end
    n_tests++;
    if (seen !== 1'b0 || fDone_Intr_o !== 1'b1) begin
      n_fail++;
      $display("FAIL no_4th_req: req seen=%b done_intr=%b required 0 1", seen, fDone_Intr_o);
    end
    exp_q.push_back(32'h0003_0003);
    exp_q.push_back(32'h0000_0006);
    wb_read(3, d);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL count_status: got %h required %h", d, e);
    end
    wb_read(0, d);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL count_ctrl_en_cleared: got %h required %h", d, e);
    end
    fifo_level_i = 0;
  endtask

  task automatic test_w1c_race;
    logic [31:0] d, e;
    bit found;
    wb_write(3, 32'h3, 4'hF);
    wb_write(2, 32'd0, 4'hF);
    wb_write(0, 32'h5, 4'hF);
    fifo_level_i = 16;
    wait_req(found);
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL race_req: req=%b required 1", SDMA_Req_o);
    end
    SDMA_Active_i = 1'b1;
    @(negedge WB_CLK);
    SDMA_Active_i  = 1'b0;
    // W1C of DMA_ST lands on the same edge that samples Done.
    WBs_ADR_i      = AW'(3);
    WBs_WE_i       = 1'b1;
    WBs_WR_DAT_i   = 32'h2;
    WBs_BYTE_STB_i = 4'b0001;
    WBs_CYC_i      = 1'b1;
    WBs_STB_i      = 1'b1;
    SDMA_Done_i    = 1'b1;
    fifo_level_i   = 0;
    @(negedge WB_CLK);
    SDMA_Done_i = 1'b0;
    n_tests++;
    if (WBs_ACK_o !== 1'b1 || f_DMA_Intr_o !== 1'b1) begin
      n_fail++;
      $display("FAIL race_ack_intr: ack=%b intr=%b required 1 1", WBs_ACK_o, f_DMA_Intr_o);
    end
    WBs_CYC_i = 1'b0;
    WBs_STB_i = 1'b0;
    WBs_WE_i  = 1'b0;
    exp_q.push_back(32'h0001_0002);
    wb_read(3, d);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL race_dma_st: got %h required %h", d, e);
    end
    wb_write(3, 32'h2, 4'b0001);
    n_tests++;
    if (f_DMA_Intr_o !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_intr_fall: got %b required 0", f_DMA_Intr_o);
    end
    exp_q.push_back(32'h0001_0000);
    wb_read(3, d);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL w1c_dma_st: got %h required %h", d, e);
    end
  endtask

  task automatic test_en_clear;
    logic [31:0] d, e;
    int w;
    bit found, ok, seen;
    wb_write(2, 32'd0, 4'hF);
    wb_write(0, 32'h1, 4'hF);
    fifo_level_i = 16;
    wait_req(found);
    wb_write(0, 32'h0, 4'hF);
    repeat (2) @(negedge WB_CLK);
    n_tests++;
    if (!found || SDMA_Req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL en_clear_req_held: req=%b required 1", SDMA_Req_o);
    end
    serve_burst(w, ok);
    seen = 1'b0;
    repeat (12) begin
      @(negedge WB_CLK);
      seen |= SDMA_Req_o;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL en_clear_no_more_req: req seen=%b required 0", seen);
    end
    exp_q.push_back(32'h0001_0002);
    wb_read(3, d);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL en_clear_status: got %h required %h", d, e);
    end
    fifo_level_i = 0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, e;
    bit found;
    wb_write(0, 32'h7, 4'hF);
    fifo_level_i = 16;
    wait_req(found);
    SDMA_Active_i = 1'b1;
    @(negedge WB_CLK);
    SDMA_Active_i = 1'b0;
    WB_RST = 1'b1;
    @(negedge WB_CLK);
    WB_RST = 1'b0;
    SDMA_Done_i = 1'b1;
    @(negedge WB_CLK);
    SDMA_Done_i = 1'b0;
    repeat (4) @(negedge WB_CLK);
    n_tests++;
    if (!found || SDMA_Req_o !== 1'b0 || f_DMA_Intr_o !== 1'b0 || fDone_Intr_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: found=%b req=%b dma=%b done=%b required 1 0 0 0",
               found, SDMA_Req_o, f_DMA_Intr_o, fDone_Intr_o);
    end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int a = 3; a >= 2; a--) begin
      wb_read((a == 3) ? 3 : 0, d);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL reset_mid_reg%0d: got %h required %h", (a == 3) ? 3 : 0, d, e);
      end
    end
    fifo_level_i = 0;
  endtask

  task automatic test_byte_strobe;
    logic [31:0] d, e;
    wb_write(1, 32'hFFFF_FFFF, 4'b0001);
    exp_q.push_back(32'h0000_00FF);
    wb_read(1, d);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL bytestb_thresh_b0: got %h required %h", d, e);
    end
    wb_write(1, 32'h0000_0100, 4'b0010);
    exp_q.push_back(32'h0000_01FF);
    wb_read(1, d);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL bytestb_thresh_b1: got %h required %h", d, e);
    end
    wb_write(2, 32'h0000_1234, 4'hF);
    wb_write(2, 32'h0000_AB56, 4'b0001);
    exp_q.push_back(32'h0000_1256);
    wb_read(2, d);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL bytestb_count: got %h required %h", d, e);
    end
    wb_write(5, 32'hFFFF_FFFF, 4'hF);
    exp_q.push_back(32'h0);
    wb_read(5, d);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL unmapped_read: got %h required %h", d, e);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_count();
    test_w1c_race();
    test_en_clear();
    test_reset_mid();
    test_byte_strobe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdma_req_ctrl.md
# sdma_req_ctrl

Wishbone-programmable SDMA request sequencer inside the FPGA IP, between the fabric data FIFO and the cell macro's SDMA channel 0. It watches a FIFO fill level, raises SDMA requests when a programmed threshold is reached, and tracks the Active/Done handshake. It counts completed bursts and drives the DMA-done and transfer-done interrupt lines back to the cell macro.

## Interface
Parameters:
- ADDRWIDTH, 7: word-address width of the register window
- LVL_WIDTH, 9: FIFO level / threshold width
- CNT_WIDTH, 16: burst-count width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - WB_CLK  in  1  block clock
  - WB_RST  in  1  synchronous active-high reset
- Wishbone slave:
  - WBs_ADR_i  in  ADDRWIDTH  word address
  - WBs_CYC_i  in  1  cycle select for this block
  - WBs_BYTE_STB_i  in  4  byte enables
  - WBs_WE_i  in  1  write enable
  - WBs_STB_i  in  1  strobe
  - WBs_WR_DAT_i  in  32  write data
  - WBs_RD_DAT_o  out  32  read data
  - WBs_ACK_o  out  1  acknowledge
- Data path and SDMA:
  - fifo_level_i  in  LVL_WIDTH  current words available
  - SDMA_Req_o  out  1  burst request to SDMA
  - SDMA_Sreq_o  out  1  single request; driven 0, reserved
  - SDMA_Active_i  in  1  SDMA servicing the channel
  - SDMA_Done_i  in  1  one-cycle burst-complete pulse
- Interrupts:
  - fDone_Intr_o  out  1  transfer-complete interrupt
  - f_DMA_Intr_o  out  1  per-burst interrupt

## Operation
- Registers (word offsets). Writes honour byte strobes. Unmapped addresses read 0 and ignore writes.
  - 0 CTRL: [0] EN, [1] DONE_IE, [2] DMA_IE.
  - 1 THRESH: [LVL_WIDTH-1:0]. A value of 0 means never trigger.
  - 2 COUNT: [CNT_WIDTH-1:0] bursts to perform; 0 = unlimited. Any write to COUNT clears COMPLETED.
  - 3 STATUS:
    - [0] DONE_ST, W1C
    - [1] DMA_ST, W1C
    - [2] BUSY, RO, high whenever the FSM is not in IDLE
    - [31:16] COMPLETED, RO, zero-extended
- FSM states: IDLE, REQ, XFER, GAP.
  - IDLE→REQ when EN & THRESH≠0 & fifo_level_i ≥ THRESH.
  - REQ: SDMA_Req_o=1. On SDMA_Active_i → XFER. If SDMA_Done_i arrives while still in REQ, treat it as a completed burst (see XFER).
  - XFER: SDMA_Req_o=0. On SDMA_Done_i → GAP, with these actions:
    - increment COMPLETED, which wraps at all-ones;
    - set DMA_ST;
    - if COUNT≠0 and the new COMPLETED = COUNT: set DONE_ST and clear EN.
  - GAP: one cycle, then IDLE. This lets the FIFO level settle before the next trigger.
- Clearing EN in REQ or XFER does not abort the burst. The request is held until Active, the burst finishes, and the FSM then stays in IDLE.
- Interrupts are registered levels:
  - fDone_Intr_o = DONE_ST & DONE_IE
  - f_DMA_Intr_o = DMA_ST & DMA_IE
- Simultaneous events:
  - A hardware set of DONE_ST or DMA_ST in the same cycle as a W1C to that bit: the set wins.
  - A CPU write of EN=1 in the same cycle as the hardware clear of EN: the hardware clear wins.

## Timing
- Reset: all outputs are 0. CTRL=0, THRESH=0, COUNT=0, STATUS=0, FSM=IDLE.
- Wishbone:
  - WBs_ACK_o = registered (CYC & STB & ~ACK). It asserts the cycle after the strobe and lasts exactly one cycle.
  - A write takes effect on the ACK edge.
  - Read data is registered and valid while ACK is high.
- Trigger latency: fifo_level_i crossing THRESH in cycle n gives SDMA_Req_o=1 in cycle n+1.
- Req falls the cycle after SDMA_Active_i is first sampled high.
- After a Done pulse in cycle n:
  - COMPLETED, DMA_ST and the interrupt outputs update at n+1;
  - the earliest next Req is at n+3 (GAP at n+1, IDLE at n+2).
- Reset asserted mid-burst returns the block to IDLE on the next edge. A Done pulse arriving later is ignored.

## Structure
- Shared package (sdma_req_ctrl_pkg) holds:
  - the register offset constants;
  - CTRL/STATUS bit indices;
  - the FSM state enum.
- One natural sub-module, sdma_req_regs: the Wishbone register file, ACK generation and W1C logic. The FSM and counters stay in the top module.

## Test plan
- Reset, then read all registers → all 0; SDMA_Req_o, both interrupts and WBs_ACK_o are 0.
- THRESH=8, COUNT=0, EN=1, fifo_level_i steps 7→8 → Req high the next cycle.
  - Active one cycle later → Req drops.
  - Done pulse → COMPLETED=1 and DMA_ST=1.
  - With DMA_IE=1, f_DMA_Intr_o rises the cycle after Done.
- COUNT=3, level held ≥ THRESH, each Req answered → exactly 3 bursts; DONE_ST=1; EN reads 0; fDone_Intr_o=1 with DONE_IE; no 4th Req.
- W1C DMA_ST in the same cycle as a Done pulse → DMA_ST reads 1. A plain W1C afterwards → DMA_ST reads 0 and f_DMA_Intr_o falls.
- Clear EN while in REQ → Req holds until Active, the burst completes, and no further Req follows.
- Assert WB_RST during XFER, then send a Done pulse → COMPLETED=0, STATUS=0, BUSY=0.
- Byte-strobe write 0x0000_00FF to THRESH with only BYTE_STB=4'b0001 → reads back 0xFF. Upper bytes are unchanged; for LVL_WIDTH=9, bit 8 stays 0.
